// File: rtl/led_bcd_scheduler_if.sv
// Request/result bundle between the LED display logic and the shared BCD
// conversion scheduler: refresh request, three binary counters, three BCD results.
interface led_bcd_scheduler_if;
  logic        refresh_tick;
  logic [31:0] total_cycles;
  logic [31:0] uncondi_branch_num;
  logic [31:0] condi_branch_num;
  logic [31:0] total_cycles_bcd;
  logic [31:0] uncondi_bcd;
  logic [31:0] condi_bcd;
  logic [2:0]  ovf;
  logic        busy;
  logic        done;

  modport master (
    output refresh_tick, total_cycles, uncondi_branch_num, condi_branch_num,
    input  total_cycles_bcd, uncondi_bcd, condi_bcd, ovf, busy, done
  );

  modport slave (
    input  refresh_tick, total_cycles, uncondi_branch_num, condi_branch_num,
    output total_cycles_bcd, uncondi_bcd, condi_bcd, ovf, busy, done
  );
endinterface

// File: rtl/led_bcd_scheduler.sv
// One sequential double-dabble engine time-shared round-robin across the three
// LED performance counters; results land in held 8-digit BCD registers.
module led_bcd_scheduler #(
  parameter bit SATURATE = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  led_bcd_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    STORE = 2'd3
  } state_e;

  localparam logic [31:0] SAT_LIMIT = 32'd100_000_000;
  localparam logic [31:0] SAT_BCD   = 32'h9999_9999;

  state_e            state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic              pending_q, pending_d;
  logic [2:0][31:0]  snap_q, snap_d;
  logic [31:0]       sreg_q, sreg_d;
  logic [31:0]       breg_q, breg_d;
  logic [2:0][31:0]  bcd_q, bcd_d;
  logic [2:0]        ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start;
  logic              sat;
  logic [31:0]       cur_snap;
  logic [31:0]       adj;

  function automatic logic [31:0] dabble_adj(input logic [31:0] s);
    logic [31:0] r;
    logic [3:0]  nib;
    r = s;
    for (int i = 0; i < 8; i++) begin
      nib = s[4*i +: 4];
      r[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
    return r;
  endfunction

  assign start    = bus.refresh_tick | pending_q;
  assign cur_snap = snap_q[ch_q];
  assign adj      = dabble_adj(sreg_q);
  // Saturation looks at the binary snapshot, not at the (mod 10^8) BCD result.
  assign sat      = SATURATE && (cur_snap >= SAT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = (bitcnt_q == 5'd31) ? STORE : SHIFT;
      STORE:   state_d = (ch_q == 2'd2) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_d      = ch_q;
    bitcnt_d  = bitcnt_q;
    pending_d = pending_q;
    snap_d    = snap_q;
    sreg_d    = sreg_q;
    breg_d    = breg_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    busy_d    = (state_d != IDLE);
    // Any request outside IDLE (including during the final STORE) is remembered once.
    if (state_q != IDLE && bus.refresh_tick) begin
      pending_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d[0] = bus.total_cycles;
          snap_d[1] = bus.uncondi_branch_num;
          snap_d[2] = bus.condi_branch_num;
          pending_d = 1'b0;
          ch_d      = 2'd0;
        end
      end
      LOAD: begin
        sreg_d   = 32'd0;
        breg_d   = cur_snap;
        bitcnt_d = 5'd0;
      end
      SHIFT: begin
        sreg_d   = (adj << 1) | {31'd0, breg_q[31]};
        breg_d   = breg_q << 1;
        bitcnt_d = bitcnt_q + 5'd1;
      end
      STORE: begin
        bcd_d[ch_q] = sat ? SAT_BCD : sreg_q;
        ovf_d[ch_q] = sat;
        if (ch_q == 2'd2) begin
          done_d = 1'b1;
        end else begin
          ch_d = ch_q + 2'd1;
        end
      end
      default: begin
        ch_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q      <= 2'd0;
      bitcnt_q  <= 5'd0;
      pending_q <= 1'b0;
      snap_q    <= '0;
      sreg_q    <= 32'd0;
      breg_q    <= 32'd0;
      bcd_q     <= '0;
      ovf_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ch_q      <= ch_d;
      bitcnt_q  <= bitcnt_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
      sreg_q    <= sreg_d;
      breg_q    <= breg_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.total_cycles_bcd = bcd_q[0];
  assign bus.uncondi_bcd      = bcd_q[1];
  assign bus.condi_bcd        = bcd_q[2];
  assign bus.ovf              = ovf_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_led_bcd_scheduler.sv
// Bench for led_bcd_scheduler: a saturating and a wrapping instance driven in lockstep,
// checked against a decimal-arithmetic reference model.
module tb_led_bcd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [31:0] in_a, in_b, in_c;
  logic [31:0] nx_a, nx_b, nx_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_bcd_scheduler_if bs();
  led_bcd_scheduler_if bn();

  assign bs.refresh_tick       = tick;
  assign bs.total_cycles       = in_a;
  assign bs.uncondi_branch_num = in_b;
  assign bs.condi_branch_num   = in_c;
  assign bn.refresh_tick       = tick;
  assign bn.total_cycles       = in_a;
  assign bn.uncondi_branch_num = in_b;
  assign bn.condi_branch_num   = in_c;

  led_bcd_scheduler #(.SATURATE(1'b1)) dut_sat (.clk(clk), .rst(rst), .bus(bs));
  led_bcd_scheduler #(.SATURATE(1'b0)) dut_raw (.clk(clk), .rst(rst), .bus(bn));

  // Reference: decimal digits of the value, or all nines when saturating above 10^8-1.
  function automatic logic [31:0] model_bcd(input logic [31:0] v, input bit sat);
    logic [31:0]     r;
    longint unsigned m;
    r = 32'd0;
    if (sat && longint'(v) >= 64'd100000000) return 32'h9999_9999;
    m = longint'(v) % 64'd100000000;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(m % 64'd10);
      m = m / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [2:0] model_ovf(input logic [31:0] a, b, c, input bit sat);
    logic [2:0] r;
    r[0] = sat && (longint'(a) >= 64'd100000000);
    r[1] = sat && (longint'(b) >= 64'd100000000);
    r[2] = sat && (longint'(c) >= 64'd100000000);
    return r;
  endfunction

  // Results captured at each done pulse: [k][0..2] saturating, [k][3..5] wrapping.
  logic [31:0] cap [0:3][0:5];
  logic [2:0]  cap_ovf_s [0:3];
  logic [2:0]  cap_ovf_n [0:3];
  logic        cap_busy [0:3];
  int          done_t [0:3];
  int          done_cnt;
  int          done_diff;
  logic        busy0;
  logic [31:0] rcap_or;
  logic [9:0]  rcap_flags;

  // Runs cycles 0..limit; tk* mark edges where a tick is sampled, chg_at swaps in nx_*,
  // rst_at pulses reset. A value of -1 means "never".
  task automatic window(input int tk0, tk1, tk2, tk3, chg_at, rst_at, limit);
    done_cnt  = 0;
    done_diff = 0;
    for (int k = 0; k < 4; k++) done_t[k] = -1;
    for (int n = 0; n <= limit; n++) begin
      tick = (n == tk0) || (n == tk1) || (n == tk2) || (n == tk3);
      if (n == chg_at) begin
        in_a = nx_a; in_b = nx_b; in_c = nx_c;
      end
      rst = (n == rst_at);
      @(posedge clk);
      @(negedge clk);
      tick = 1'b0;
      rst  = 1'b0;
      if (n == 0) busy0 = bs.busy;
      if (n == rst_at) begin
        rcap_or = bs.total_cycles_bcd | bs.uncondi_bcd | bs.condi_bcd
                | bn.total_cycles_bcd | bn.uncondi_bcd | bn.condi_bcd;
        rcap_flags = {bs.ovf, bn.ovf, bs.busy, bs.done, bn.busy, bn.done};
      end
      if (bs.done !== bn.done) done_diff++;
      if (bs.done === 1'b1) begin
        if (done_cnt < 4) begin
          cap[done_cnt][0] = bs.total_cycles_bcd;
          cap[done_cnt][1] = bs.uncondi_bcd;
          cap[done_cnt][2] = bs.condi_bcd;
          cap[done_cnt][3] = bn.total_cycles_bcd;
          cap[done_cnt][4] = bn.uncondi_bcd;
          cap[done_cnt][5] = bn.condi_bcd;
          cap_ovf_s[done_cnt] = bs.ovf;
          cap_ovf_n[done_cnt] = bn.ovf;
          cap_busy[done_cnt]  = bs.busy;
          done_t[done_cnt]    = n;
        end
        done_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0;
    in_a = 32'd0; in_b = 32'd0; in_c = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bs.total_cycles_bcd, bs.uncondi_bcd, bs.condi_bcd} !== 96'd0) begin
      failures++;
      $display("FAIL reset_bcd got=%h/%h/%h want=0", bs.total_cycles_bcd, bs.uncondi_bcd, bs.condi_bcd);
    end
    checks++;
    if ({bs.ovf, bs.busy, bs.done, bn.ovf, bn.busy, bn.done} !== 10'd0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0", {bs.ovf, bs.busy, bs.done, bn.ovf, bn.busy, bn.done});
    end
  endtask

  // One sweep started at edge 0 with current inputs; checks timing and all six results.
  task automatic sweep_and_check(input string name);
    logic [31:0] ea, eb, ec;
    ea = in_a; eb = in_b; ec = in_c;
    window(0, -1, -1, -1, -1, -1, 130);
    checks++;
    if (busy0 !== 1'b1) begin
      failures++; $display("FAIL %s_busy_after_tick got=%b want=1", name, busy0);
    end
    checks++;
    if (done_cnt != 1 || done_t[0] != 102) begin
      failures++; $display("FAIL %s_done_timing got cnt=%0d at=%0d want cnt=1 at=102", name, done_cnt, done_t[0]);
    end
    checks++;
    if (done_diff != 0) begin
      failures++; $display("FAIL %s_done_lockstep got diff=%0d want=0", name, done_diff);
    end
    if (done_cnt >= 1) begin
      checks++;
      if (cap_busy[0] !== 1'b0) begin
        failures++; $display("FAIL %s_busy_at_done got=%b want=0", name, cap_busy[0]);
      end
      checks++;
      if (cap[0][0] !== model_bcd(ea, 1'b1) || cap[0][1] !== model_bcd(eb, 1'b1) || cap[0][2] !== model_bcd(ec, 1'b1)) begin
        failures++;
        $display("FAIL %s_sat_bcd got=%h/%h/%h want=%h/%h/%h", name, cap[0][0], cap[0][1], cap[0][2],
                 model_bcd(ea, 1'b1), model_bcd(eb, 1'b1), model_bcd(ec, 1'b1));
      end
      checks++;
      if (cap[0][3] !== model_bcd(ea, 1'b0) || cap[0][4] !== model_bcd(eb, 1'b0) || cap[0][5] !== model_bcd(ec, 1'b0)) begin
        failures++;
        $display("FAIL %s_raw_bcd got=%h/%h/%h want=%h/%h/%h", name, cap[0][3], cap[0][4], cap[0][5],
                 model_bcd(ea, 1'b0), model_bcd(eb, 1'b0), model_bcd(ec, 1'b0));
      end
      checks++;
      if (cap_ovf_s[0] !== model_ovf(ea, eb, ec, 1'b1) || cap_ovf_n[0] !== 3'b000) begin
        failures++;
        $display("FAIL %s_ovf got=%b/%b want=%b/000", name, cap_ovf_s[0], cap_ovf_n[0], model_ovf(ea, eb, ec, 1'b1));
      end
    end
  endtask

  task automatic test_directed();
    in_a = 32'd0; in_b = 32'd0; in_c = 32'd0;
    sweep_and_check("zeros");
    in_a = 32'd12345678; in_b = 32'd99999999; in_c = 32'd10;
    sweep_and_check("digits");
    checks++;
    if (cap[0][0] !== 32'h1234_5678 || cap[0][1] !== 32'h9999_9999 || cap[0][2] !== 32'h0000_0010) begin
      failures++;
      $display("FAIL digits_literal got=%h/%h/%h want=12345678/99999999/00000010", cap[0][0], cap[0][1], cap[0][2]);
    end
    in_c = 32'hFFFF_FFFF;
    sweep_and_check("max");
    checks++;
    if (cap[0][2] !== 32'h9999_9999 || cap_ovf_s[0] !== 3'b100 || cap[0][5] !== 32'h9496_7295) begin
      failures++;
      $display("FAIL max_literal got sat=%h ovf=%b raw=%h want sat=99999999 ovf=100 raw=94967295",
               cap[0][2], cap_ovf_s[0], cap[0][5]);
    end
  endtask

  task automatic test_random();
    logic [31:0] v [0:2];
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < 3; c++) begin
        case ($urandom_range(0, 3))
          0:       v[c] = 32'($urandom_range(0, 99999999));
          1:       v[c] = $urandom;
          2:       v[c] = 32'd99999999 + 32'($urandom_range(0, 1));
          default: v[c] = 32'($urandom_range(0, 9999));
        endcase
      end
      in_a = v[0]; in_b = v[1]; in_c = v[2];
      sweep_and_check("random");
    end
  endtask

  // Inputs change at edge 40 and a second tick lands at edge 50 during the first sweep.
  task automatic test_snapshot();
    logic [31:0] aa, ab, ac;
    aa = 32'd87654321; ab = 32'd100000000; ac = 32'd5;
    in_a = aa; in_b = ab; in_c = ac;
    nx_a = 32'd42; nx_b = 32'd7777777; nx_c = 32'd3000000000;
    window(0, 50, -1, -1, 40, -1, 240);
    checks++;
    if (done_cnt != 2 || done_t[0] != 102 || done_t[1] != 205) begin
      failures++;
      $display("FAIL snapshot_timing got cnt=%0d at=%0d,%0d want cnt=2 at=102,205", done_cnt, done_t[0], done_t[1]);
    end
    checks++;
    if (cap[0][0] !== model_bcd(aa, 1'b1) || cap[0][1] !== model_bcd(ab, 1'b1) || cap[0][2] !== model_bcd(ac, 1'b1)
        || cap_ovf_s[0] !== model_ovf(aa, ab, ac, 1'b1)) begin
      failures++;
      $display("FAIL snapshot_first got=%h/%h/%h ovf=%b want=%h/%h/%h ovf=%b", cap[0][0], cap[0][1], cap[0][2], cap_ovf_s[0],
               model_bcd(aa, 1'b1), model_bcd(ab, 1'b1), model_bcd(ac, 1'b1), model_ovf(aa, ab, ac, 1'b1));
    end
    checks++;
    if (cap[1][0] !== model_bcd(nx_a, 1'b1) || cap[1][1] !== model_bcd(nx_b, 1'b1) || cap[1][2] !== model_bcd(nx_c, 1'b1)
        || cap[1][5] !== model_bcd(nx_c, 1'b0)) begin
      failures++;
      $display("FAIL snapshot_second got=%h/%h/%h raw=%h want=%h/%h/%h raw=%h", cap[1][0], cap[1][1], cap[1][2], cap[1][5],
               model_bcd(nx_a, 1'b1), model_bcd(nx_b, 1'b1), model_bcd(nx_c, 1'b1), model_bcd(nx_c, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    in_a = 32'd11111111; in_b = 32'd22222222; in_c = 32'd33333333;
    window(0, -1, -1, -1, -1, 60, 130);
    checks++;
    if (rcap_or !== 32'd0 || rcap_flags !== 10'd0) begin
      failures++;
      $display("FAIL reset_mid_clear got or=%h flags=%b want 0/0", rcap_or, rcap_flags);
    end
    checks++;
    if (done_cnt != 0) begin
      failures++; $display("FAIL reset_mid_no_done got=%0d want=0", done_cnt);
    end
    in_a = 32'($urandom_range(0, 99999999)); in_b = $urandom; in_c = 32'd9;
    sweep_and_check("after_reset");
  endtask

  task automatic test_back_to_back();
    in_a = 32'd314159; in_b = 32'd2718281; in_c = 32'd141421356;
    window(0, 10, 20, 30, -1, -1, 330);
    checks++;
    if (done_cnt != 2 || done_t[0] != 102 || done_t[1] != 205) begin
      failures++;
      $display("FAIL b2b_three_ticks got cnt=%0d at=%0d,%0d want cnt=2 at=102,205", done_cnt, done_t[0], done_t[1]);
    end
    checks++;
    if (done_cnt >= 2 && (cap[1][0] !== model_bcd(in_a, 1'b1) || cap[1][2] !== model_bcd(in_c, 1'b1))) begin
      failures++;
      $display("FAIL b2b_values got=%h/%h want=%h/%h", cap[1][0], cap[1][2], model_bcd(in_a, 1'b1), model_bcd(in_c, 1'b1));
    end
    window(0, 102, -1, -1, -1, -1, 330);
    checks++;
    if (done_cnt != 2 || done_t[0] != 102 || done_t[1] != 205) begin
      failures++;
      $display("FAIL b2b_tick_at_store got cnt=%0d at=%0d,%0d want cnt=2 at=102,205", done_cnt, done_t[0], done_t[1]);
    end
  endtask

  initial begin
    tick = 1'b0; rst = 1'b1;
    in_a = 32'd0; in_b = 32'd0; in_c = 32'd0;
    nx_a = 32'd0; nx_b = 32'd0; nx_c = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
